buttons: RTL and testbench

- Request-latch block for the elevator controller.
- Captures momentary cabin (floor-number) and hall (up/down) button presses into per-floor sticky request registers.
- Holds each request until the motion controller clears it after servicing that floor.
- Sits between the raw button inputs and the elevator scheduling FSM.

---
 rtl/buttons_pkg.sv | 33 +++
 rtl/button_latch_bank.sv | 35 +++
 rtl/buttons.sv | 98 +++++++++
 tb/tb_buttons.sv | 136 +++++++++++++
 4 files changed

// File: rtl/buttons_pkg.sv
// Shared floor-count constants, floor-vector type and per-group valid-mask helper
// for the elevator button request latches.
package buttons_pkg;

  localparam int BUTTONS_WIDTH_DEFAULT = 8;
  localparam int BOTTOM_FLOOR          = 0;
  localparam int TOP_FLOOR             = BUTTONS_WIDTH_DEFAULT - 1;

  typedef logic [BUTTONS_WIDTH_DEFAULT-1:0] floor_vec_t;

  typedef enum logic [1:0] {
    GRP_IN   = 2'd0,
    GRP_UP   = 2'd1,
    GRP_DOWN = 2'd2
  } btn_group_e;

  // Up at the top floor and down at the bottom floor are meaningless calls.
  function automatic logic [63:0] group_valid_mask(input btn_group_e grp, input int width);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < width; i++) begin
      m[i] = 1'b1;
    end
    if (grp == GRP_UP) begin
      m[width-1] = 1'b0;
    end
    if (grp == GRP_DOWN) begin
      m[BOTTOM_FLOOR] = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/button_latch_bank.sv
// Vector of sticky set/clear request registers; clear wins over set, and bits
// outside VALID_MASK are held at 0.
module button_latch_bank
  import buttons_pkg::*;
#(
  parameter int                 WIDTH      = BUTTONS_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0]   VALID_MASK = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] set_in,
  input  logic [WIDTH-1:0] clr_in,
  output logic [WIDTH-1:0] active_out,
  output logic [WIDTH-1:0] active_next
);

  logic [WIDTH-1:0] active_d;
  logic [WIDTH-1:0] active_q;

  always_comb begin
    active_d = reset ? '0 : ((active_q | (set_in & VALID_MASK)) & ~clr_in);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= '0;
    end else begin
      active_q <= active_d;
    end
  end

  assign active_out  = active_q;
  assign active_next = active_d;

endmodule

// File: rtl/buttons.sv
// Elevator request latch: cabin, hall-up and hall-down presses held until cleared.
// Define BUTTONS_SYNC_EN to pass every button through a two-flop synchronizer first.
module buttons
  import buttons_pkg::*;
#(
  parameter int BUTTONS_WIDTH = BUTTONS_WIDTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [BUTTONS_WIDTH-1:0] btn_num_in,
  input  logic [BUTTONS_WIDTH-1:0] btn_up_out,
  input  logic [BUTTONS_WIDTH-1:0] btn_down_out,
  input  logic [BUTTONS_WIDTH-1:0] clr_in_levels,
  input  logic [BUTTONS_WIDTH-1:0] clr_up_levels,
  input  logic [BUTTONS_WIDTH-1:0] clr_down_levels,
  output logic [BUTTONS_WIDTH-1:0] active_in_levels,
  output logic [BUTTONS_WIDTH-1:0] active_out_up_levels,
  output logic [BUTTONS_WIDTH-1:0] active_out_down_levels,
  output logic                     any_active
);

  localparam int NUM_GROUPS = 3;

  localparam logic [NUM_GROUPS-1:0][BUTTONS_WIDTH-1:0] VALID_MASKS = {
    BUTTONS_WIDTH'(group_valid_mask(GRP_DOWN, BUTTONS_WIDTH)),
    BUTTONS_WIDTH'(group_valid_mask(GRP_UP,   BUTTONS_WIDTH)),
    BUTTONS_WIDTH'(group_valid_mask(GRP_IN,   BUTTONS_WIDTH))
  };

  logic [NUM_GROUPS-1:0][BUTTONS_WIDTH-1:0] btn_raw;
  logic [NUM_GROUPS-1:0][BUTTONS_WIDTH-1:0] btn_set;
  logic [NUM_GROUPS-1:0][BUTTONS_WIDTH-1:0] clr_vec;
  logic [NUM_GROUPS-1:0][BUTTONS_WIDTH-1:0] active_vec;
  logic [NUM_GROUPS-1:0][BUTTONS_WIDTH-1:0] next_vec;

  assign btn_raw = {btn_down_out, btn_up_out, btn_num_in};
  assign clr_vec = {clr_down_levels, clr_up_levels, clr_in_levels};

`ifdef BUTTONS_SYNC_EN
  logic [NUM_GROUPS-1:0][BUTTONS_WIDTH-1:0] sync_meta_d, sync_meta_q;
  logic [NUM_GROUPS-1:0][BUTTONS_WIDTH-1:0] sync_out_d,  sync_out_q;

  always_comb begin
    sync_meta_d = btn_raw;
    sync_out_d  = sync_meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta_q <= '0;
      sync_out_q  <= '0;
    end else begin
      sync_meta_q <= sync_meta_d;
      sync_out_q  <= sync_out_d;
    end
  end

  assign btn_set = sync_out_q;
`else
  assign btn_set = btn_raw;
`endif

  for (genvar gi = 0; gi < NUM_GROUPS; gi++) begin : g_bank
    button_latch_bank #(
      .WIDTH      (BUTTONS_WIDTH),
      .VALID_MASK (VALID_MASKS[gi])
    ) u_bank (
      .clk         (clk),
      .reset       (reset),
      .set_in      (btn_set[gi]),
      .clr_in      (clr_vec[gi]),
      .active_out  (active_vec[gi]),
      .active_next (next_vec[gi])
    );
  end

  // Built from next-state so it lands on the same edge as the request vectors.
  logic any_active_d;
  logic any_active_q;

  always_comb begin
    any_active_d = |next_vec;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      any_active_q <= 1'b0;
    end else begin
      any_active_q <= any_active_d;
    end
  end

  assign active_in_levels       = active_vec[GRP_IN];
  assign active_out_up_levels   = active_vec[GRP_UP];
  assign active_out_down_levels = active_vec[GRP_DOWN];
  assign any_active             = any_active_q;

endmodule

// File: tb/tb_buttons.sv
// Directed + short random bench for buttons (default build, 1-edge latency),
// scoreboard of expected outputs checked one edge after each driven step.
module tb_buttons;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] btn_num_in, btn_up_out, btn_down_out;
  logic [7:0] clr_in_levels, clr_up_levels, clr_down_levels;
  logic [7:0] active_in_levels, active_out_up_levels, active_out_down_levels;
  logic       any_active;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [7:0] in_v;
    logic [7:0] up_v;
    logic [7:0] down_v;
    logic       any_v;
  } exp_t;

  exp_t sb[$];

  logic [7:0] m_in, m_up, m_down;

  always #5 clk = ~clk;

  buttons #(.BUTTONS_WIDTH(8)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .btn_num_in             (btn_num_in),
    .btn_up_out             (btn_up_out),
    .btn_down_out           (btn_down_out),
    .clr_in_levels          (clr_in_levels),
    .clr_up_levels          (clr_up_levels),
    .clr_down_levels        (clr_down_levels),
    .active_in_levels       (active_in_levels),
    .active_out_up_levels   (active_out_up_levels),
    .active_out_down_levels (active_out_down_levels),
    .any_active             (any_active)
  );

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input string tag, input logic rst,
                      input logic [7:0] num, input logic [7:0] up, input logic [7:0] down,
                      input logic [7:0] cin, input logic [7:0] cup, input logic [7:0] cdown);
    exp_t e;
    reset = rst; btn_num_in = num; btn_up_out = up; btn_down_out = down;
    clr_in_levels = cin; clr_up_levels = cup; clr_down_levels = cdown;
    if (rst) begin
      m_in = 8'h00; m_up = 8'h00; m_down = 8'h00;
    end else begin
      m_in   = (m_in   | num)            & ~cin;
      m_up   = (m_up   | (up   & 8'h7F)) & ~cup;
      m_down = (m_down | (down & 8'hFE)) & ~cdown;
    end
    e.tag = tag; e.in_v = m_in; e.up_v = m_up; e.down_v = m_down;
    e.any_v = (m_in != 0) || (m_up != 0) || (m_down != 0);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check8({e.tag, ".in"},   active_in_levels,       e.in_v);
    check8({e.tag, ".up"},   active_out_up_levels,   e.up_v);
    check8({e.tag, ".down"}, active_out_down_levels, e.down_v);
    check8({e.tag, ".any"},  {7'b0, any_active},     {7'b0, e.any_v});
    $display("step %-10s in=%02h up=%02h down=%02h any=%0b", e.tag,
             active_in_levels, active_out_up_levels, active_out_down_levels, any_active);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_in = 8'h00; m_up = 8'h00; m_down = 8'h00;
    reset = 1'b1;
    btn_num_in = 8'h00; btn_up_out = 8'h00; btn_down_out = 8'h00;
    clr_in_levels = 8'h00; clr_up_levels = 8'h00; clr_down_levels = 8'h00;

    // reset with buttons low
    step("reset0", 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    step("reset1", 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

    // latch and hold
    step("up_pulse", 1'b0, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 10; i++) begin
      step("up_hold", 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    end

    // multi-group simultaneous press
    step("multi", 1'b0, 8'h02, 8'h20, 8'h80, 8'h00, 8'h00, 8'h00);

    // invalid hall calls masked; cabin edges valid
    step("mask_hall", 1'b0, 8'h00, 8'h80, 8'h01, 8'h00, 8'h00, 8'h00);
    step("mask_cab",  1'b0, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

    // clear priority then re-latch while held
    step("cab_press", 1'b0, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    step("clr_prio",  1'b0, 8'h04, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00);
    step("relatch",   1'b0, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    step("release",   1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

    // group clears are independent
    step("clr_hall",  1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h80);

    // reset mid-operation
    step("dn_press",  1'b0, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00);
    step("mid_reset", 1'b1, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    step("post_rst",  1'b0, 8'h10, 8'h04, 8'h02, 8'h00, 8'h00, 8'h00);
    step("clr_all",   1'b0, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF);

    // random presses with sparse clears
    for (int i = 0; i < 40; i++) begin
      step("rand", 1'b0,
           8'($urandom), 8'($urandom), 8'($urandom),
           8'($urandom) & 8'($urandom), 8'($urandom) & 8'($urandom),
           8'($urandom) & 8'($urandom));
    end
    step("final_rst", 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
